// File: rtl/sys_timer_pkg.sv
// Shared definitions for the sys_timer peripheral: register offsets, ctrl bit
// positions, bus access-size codes and a byte-lane merge helper.
package sys_timer_pkg;

  localparam logic [5:0] OFF_MTIME    = 6'h00;
  localparam logic [5:0] OFF_MTIMECMP = 6'h08;
  localparam logic [5:0] OFF_CTRL     = 6'h10;
  localparam logic [5:0] OFF_STATUS   = 6'h18;
  localparam logic [5:0] OFF_PRESCALE = 6'h20;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_W        = 3;

  typedef enum logic [2:0] {
    BUS_NONE  = 3'b000,
    BUS_WORD  = 3'b011,
    BUS_DWORD = 3'b100
  } bus_size_e;

  // Replace only the bits selected by mask; the rest keep their old value.
  function automatic logic [63:0] merge64(input logic [63:0] old_val,
                                          input logic [63:0] wdata,
                                          input logic [63:0] mask);
    return (old_val & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/sys_timer_prescaler.sv
// 16-bit tick divider: one tick every prescale+1 enabled cycles; restarts from
// zero whenever disabled or cleared.
module sys_timer_prescaler
  import sys_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic [15:0] prescale,
  output logic        tick
);

  logic [15:0] cnt;

  assign tick = en && (cnt == prescale);

  always_ff @(posedge clk) begin
    if (rst || clear || !en) begin
      cnt <= '0;
    end else if (cnt == prescale) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/sys_timer.sv
// Memory-mapped 64-bit machine timer with compare, one-shot/periodic modes and
// level irq. Optional tick prescaler at 0x20 when SYS_TIMER_PRESCALER_EN is defined.
module sys_timer
  import sys_timer_pkg::*;
#(
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] addr,
  input  logic [2:0]  rd_ctrl,
  input  logic [2:0]  wr_ctrl,
  input  logic [63:0] data_in,
  output logic [63:0] data_out,
  output logic        valid,
  output logic        irq
);

  logic [63:0]       mtime, mtimecmp;
  logic [CTRL_W-1:0] ctrl;
  logic              pending;
  logic [15:0]       prescale_q;

  logic [63:0]       mtime_nxt, mtimecmp_nxt;
  logic [CTRL_W-1:0] ctrl_nxt;
  logic              pending_nxt;

  logic [5:0]  reg_sel;
  logic        rd_req, rd_ok, wr_ok;
  logic [63:0] rd_full, rd_data;
  logic [63:0] wmask, wdata;
  logic        wr_mtime, wr_mtimecmp, ctrl_we, pend_clr;
  logic        tick, match;
  logic        unused_addr;

  assign unused_addr = ^addr[63:6];
  assign reg_sel     = {addr[5:3], 3'b000};

  assign rd_req = (rd_ctrl == BUS_WORD) || (rd_ctrl == BUS_DWORD);
  assign rd_ok  = ((rd_ctrl == BUS_WORD)  && (addr[1:0] == 2'b00)) ||
                  ((rd_ctrl == BUS_DWORD) && (addr[2:0] == 3'b000));
  assign wr_ok  = ((wr_ctrl == BUS_WORD)  && (addr[1:0] == 2'b00)) ||
                  ((wr_ctrl == BUS_DWORD) && (addr[2:0] == 3'b000));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rd_full = '0;
    case (reg_sel)
      OFF_MTIME:    rd_full = mtime;
      OFF_MTIMECMP: rd_full = mtimecmp;
      OFF_CTRL:     rd_full = {{(64-CTRL_W){1'b0}}, ctrl};
      OFF_STATUS:   rd_full = {63'b0, pending};
      OFF_PRESCALE: rd_full = {48'b0, prescale_q};
      default:      rd_full = '0;
    endcase

    rd_data = '0;
    if (rd_ok) begin
      if (rd_ctrl == BUS_WORD) begin
        rd_data = addr[2] ? {32'b0, rd_full[63:32]} : {32'b0, rd_full[31:0]};
      end else begin
        rd_data = rd_full;
      end
    end
  end

  // A word write lands on one half; duplicating the data lets the mask pick it.
  always_comb begin
    wmask = '1;
    wdata = data_in;
    if (wr_ctrl == BUS_WORD) begin
      wdata = {2{data_in[31:0]}};
      wmask = addr[2] ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF};
    end
  end

  assign wr_mtime    = wr_ok && (reg_sel == OFF_MTIME);
  assign wr_mtimecmp = wr_ok && (reg_sel == OFF_MTIMECMP);
  assign ctrl_we     = wr_ok && (reg_sel == OFF_CTRL)   && wmask[0];
  assign pend_clr    = wr_ok && (reg_sel == OFF_STATUS) && wmask[0] && wdata[0];

`ifdef SYS_TIMER_PRESCALER_EN
  logic prescale_we;

  assign prescale_we = wr_ok && (reg_sel == OFF_PRESCALE) && wmask[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= '0;
    end else if (prescale_we) begin
      prescale_q <= wdata[15:0];
    end
  end

  sys_timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl[CTRL_EN]),
    .clear    (prescale_we),
    .prescale (prescale_q),
    .tick     (tick)
  );
`else
  assign prescale_q = '0;
  assign tick       = ctrl[CTRL_EN];
`endif

  assign match = tick && (mtime >= mtimecmp);

  // A bus write to mtime takes priority over the tick in the same cycle.
  always_comb begin
    mtime_nxt = mtime;
    if (wr_mtime) begin
      mtime_nxt = merge64(mtime, wdata, wmask);
    end else if (tick) begin
      mtime_nxt = (match && ctrl[CTRL_PERIODIC]) ? 64'd0 : mtime + 64'd1;
    end
    mtimecmp_nxt = wr_mtimecmp ? merge64(mtimecmp, wdata, wmask) : mtimecmp;
    ctrl_nxt     = ctrl_we ? wdata[CTRL_W-1:0] : ctrl;
    pending_nxt  = match || (pending && !pend_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware's simultaneous update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= CMP_RESET;
      ctrl     <= '0;
      pending  <= 1'b0;
      data_out <= '0;
      valid    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
      ctrl     <= ctrl_nxt;
      pending  <= pending_nxt;
      valid    <= rd_req;
      if (rd_req) begin
        data_out <= rd_data;
      end
      irq <= pending_nxt && ctrl_nxt[CTRL_IE];
    end
  end

endmodule

// File: tb/tb_sys_timer.sv
// Scoreboard bench for sys_timer: a behavioural register model predicts read
// data and irq; a monitor compares them against the DUT every cycle.
module tb_sys_timer;

  localparam logic [2:0] C_NONE  = 3'b000;
  localparam logic [2:0] C_WORD  = 3'b011;
  localparam logic [2:0] C_DWORD = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] addr;
  logic [2:0]  rd_ctrl, wr_ctrl;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        valid, irq;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_time, m_cmp;
  bit          m_en, m_per, m_ie, m_pend;
  logic [15:0] m_pre;
  int          dcount;
  logic [63:0] exp_q[$];
  bit          exp_irq = 1'b0;

  sys_timer dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .rd_ctrl  (rd_ctrl),
    .wr_ctrl  (wr_ctrl),
    .data_in  (data_in),
    .data_out (data_out),
    .valid    (valid),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [63:0] a, input logic [2:0] code);
    logic [63:0] full;
    logic [5:0]  off = a[5:0];
    if (code == C_WORD && off[1:0] != 2'd0) return 64'd0;
    if (code == C_DWORD && off[2:0] != 3'd0) return 64'd0;
    case (off[5:3])
      3'd0:    full = m_time;
      3'd1:    full = m_cmp;
      3'd2:    full = {61'd0, m_ie, m_per, m_en};
      3'd3:    full = {63'd0, m_pend};
`ifdef SYS_TIMER_PRESCALER_EN
      3'd4:    full = {48'd0, m_pre};
`endif
      default: full = 64'd0;
    endcase
    if (code == C_WORD) return off[2] ? (full >> 32) : (full & 64'h0000_0000_FFFF_FFFF);
    return full;
  endfunction

  function automatic logic [63:0] wmerge(input logic [63:0] old_val, input logic [63:0] a,
                                         input logic [2:0] code, input logic [63:0] d);
    if (code == C_DWORD) return d;
    if (a[2]) return {d[31:0], old_val[31:0]};
    return {old_val[63:32], d[31:0]};
  endfunction

  // Advances the model across one clock edge; returns the read response, if any.
  task automatic model_step(input bit r, input logic [2:0] rc, input logic [2:0] wc,
                            input logic [63:0] a, input logic [63:0] d,
                            output bit has_rd, output logic [63:0] rd_val);
    logic [5:0]  off = a[5:0];
    logic [63:0] nt;
    bit wr_ok, lo, tick, match, w1c, pre_we;
    has_rd = 1'b0;
    rd_val = 64'd0;
    if (r) begin
      m_time = 64'd0; m_cmp = '1; m_en = 0; m_per = 0; m_ie = 0; m_pend = 0;
      m_pre = 16'd0; dcount = 0;
      return;
    end
    if (rc == C_WORD || rc == C_DWORD) begin
      has_rd = 1'b1;
      rd_val = model_read(a, rc);
    end
    wr_ok = (wc == C_WORD && off[1:0] == 2'd0) || (wc == C_DWORD && off[2:0] == 3'd0);
    lo    = wr_ok && (wc == C_DWORD || !off[2]);
`ifdef SYS_TIMER_PRESCALER_EN
    tick   = m_en && (((dcount + 1) % (int'(m_pre) + 1)) == 0);
    pre_we = lo && off[5:3] == 3'd4;
    dcount = (pre_we || !m_en) ? 0 : dcount + 1;
    if (pre_we) m_pre = d[15:0];
`else
    tick   = m_en;
    pre_we = 1'b0;
`endif
    match = tick && (m_time >= m_cmp);
    nt = m_time;
    if (tick) nt = (match && m_per) ? 64'd0 : m_time + 64'd1;
    if (wr_ok && off[5:3] == 3'd0) nt = wmerge(m_time, a, wc, d);
    if (wr_ok && off[5:3] == 3'd1) m_cmp = wmerge(m_cmp, a, wc, d);
    if (lo && off[5:3] == 3'd2) {m_ie, m_per, m_en} = d[2:0];
    w1c    = lo && off[5:3] == 3'd3 && d[0];
    m_pend = match || (m_pend && !w1c);
    m_time = nt;
  endtask

  task automatic cycle(input bit r, input logic [2:0] rc, input logic [2:0] wc,
                       input logic [63:0] a, input logic [63:0] d);
    bit          has_rd;
    logic [63:0] rd_val;
    rst = r; rd_ctrl = rc; wr_ctrl = wc; addr = a; data_in = d;
    model_step(r, rc, wc, a, d, has_rd, rd_val);
    @(posedge clk);
    #1;
    if (has_rd) exp_q.push_back(rd_val);
    exp_irq = m_ie && m_pend;
  endtask

  task automatic rd(input logic [2:0] code, input logic [63:0] a);
    cycle(1'b0, code, C_NONE, a, 64'd0);
  endtask

  task automatic wr(input logic [2:0] code, input logic [63:0] a, input logic [63:0] d);
    cycle(1'b0, C_NONE, code, a, d);
  endtask

  // Monitor: every valid pops one expected read; irq is checked each cycle.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
        else check("read_data", data_out, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        check("missing_valid", {63'd0, valid}, 64'd1);
        void'(exp_q.pop_front());
      end
      check("irq", {63'd0, irq}, {63'd0, exp_irq});
    end
  end

  initial begin
    logic [5:0] offs[14] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18,
                             6'h1C, 6'h20, 6'h24, 6'h28, 6'h02, 6'h06, 6'h3C};
    logic [2:0] codes[4] = '{C_NONE, C_WORD, C_DWORD, 3'b001};

    // Read accepted in the reset cycle must not produce valid.
    cycle(1'b1, C_DWORD, C_NONE, 64'h8, 64'd0);
    @(negedge clk);
    check("reset_data_out", data_out, 64'd0);
    check("reset_valid", {63'd0, valid}, 64'd0);
    check("reset_irq", {63'd0, irq}, 64'd0);
    rd(C_DWORD, 64'h8);

    // One-shot compare with interrupt, then clear with counting stopped.
    wr(C_DWORD, 64'h08, 64'd5);
    wr(C_DWORD, 64'h10, 64'h5);
    repeat (9) rd(C_DWORD, 64'h00);
    rd(C_WORD, 64'h18);
    wr(C_WORD, 64'h10, 64'h4);
    wr(C_WORD, 64'h18, 64'h1);
    rd(C_DWORD, 64'h18);
    rd(C_DWORD, 64'h10);

    // Periodic mode wraps to 0 after each compare.
    wr(C_DWORD, 64'h10, 64'h0);
    wr(C_DWORD, 64'h00, 64'h0);
    wr(C_DWORD, 64'h08, 64'd3);
    wr(C_DWORD, 64'h10, 64'h7);
    repeat (10) rd(C_DWORD, 64'h00);

    // Word write to the upper half and a misaligned write.
    wr(C_DWORD, 64'h10, 64'h0);
    wr(C_DWORD, 64'h00, 64'h10);
    wr(C_WORD, 64'h04, 64'hDEAD_BEEF);
    rd(C_DWORD, 64'h00);
    wr(C_WORD, 64'h02, 64'h5555_5555);
    rd(C_DWORD, 64'h00);
    rd(C_WORD, 64'h04);
    rd(C_DWORD, 64'h04);

    // Bus write beats tick; W1C loses to a simultaneous set.
    wr(C_DWORD, 64'h08, '1);
    wr(C_DWORD, 64'h10, 64'h1);
    wr(C_DWORD, 64'h00, 64'h1234);
    rd(C_DWORD, 64'h00);
    wr(C_DWORD, 64'h08, 64'h0);
    wr(C_DWORD, 64'h10, 64'h5);
    repeat (3) cycle(1'b0, C_DWORD, C_WORD, 64'h18, 64'h1);
    rd(C_DWORD, 64'h18);

    // Prescale register and divided tick.
    wr(C_DWORD, 64'h10, 64'h0);
    wr(C_DWORD, 64'h00, 64'h0);
    wr(C_DWORD, 64'h08, '1);
    wr(C_DWORD, 64'h20, 64'd3);
    rd(C_DWORD, 64'h20);
    wr(C_DWORD, 64'h10, 64'h1);
    repeat (14) rd(C_DWORD, 64'h00);

    // Random traffic, including invalid codes, misalignment and resets.
    for (int i = 0; i < 600; i++) begin
      logic [63:0] a, d;
      a = {$urandom, $urandom};
      a[5:0] = offs[$urandom_range(0, 13)];
      d = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 40)) : {$urandom, $urandom};
      cycle(($urandom_range(0, 99) == 0), codes[$urandom_range(0, 3)],
            codes[$urandom_range(0, 3)], a, d);
    end

    repeat (3) cycle(1'b0, C_NONE, C_NONE, 64'd0, 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_timer.md
# sys_timer

Memory-mapped machine timer that sits downstream of `system_bus` as a peripheral alongside `gpio` and `uart_top`. It provides a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register, and one-shot or periodic operation. It drives a level interrupt line toward the core. The bus performs base-address selection; this block decodes only the offset in `addr[5:0]`.

## Interface
- `CMP_RESET`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset; one clock, sampled on the rising edge of `clk`.
- `addr`  in  64  byte address; only `[5:0]` is decoded.
- `rd_ctrl`  in  3  read request: 000 none, 011 word (32 bit), 100 doubleword (64 bit); other codes are not a read.
- `wr_ctrl`  in  3  write request, same encoding as `rd_ctrl`.
- `data_in`  in  64  write data; a word write uses `[31:0]`.
- `data_out`  out  64  registered read data; a word read is zero-extended.
- `valid`  out  1  high for exactly one cycle, the cycle after a read is accepted.
- `irq`  out  1  timer interrupt, level, `pending & ctrl.ie`.

## Operation
- Register map by offset:
  - 0x00 `mtime`, read/write.
  - 0x08 `mtimecmp`, read/write.
  - 0x10 `ctrl`: bit0 `en`, bit1 `periodic`, bit2 `ie`; other bits read 0.
  - 0x18 `status`: bit0 `pending`; writing 1 clears it.
  - 0x20 `prescale`: see Configuration.
- Word access: offset +0 targets bits `[31:0]` and offset +4 targets bits `[63:32]`. The other half is unchanged.
- Misaligned accesses are ignored: a word access not 4-aligned, or a doubleword access not 8-aligned. A read of an unmapped or misaligned location returns 0 with `valid` = 1.
- Tick: asserted every cycle while `en` = 1, or once per prescale period when the prescaler is compiled in. No tick while `en` = 0; `mtime` holds its value.
- On a tick, when `mtime >= mtimecmp` (unsigned):
  - `pending` is set.
  - If `periodic` = 1, `mtime` loads 0. Otherwise `mtime` increments.
- On a tick with no match, `mtime` increments, wrapping from 2^64-1 to 0 without a flag.
- Simultaneous events:
  - A bus write to `mtime` in the same cycle as a tick wins; the tick is dropped.
  - A W1C of `pending` in the same cycle as a set leaves `pending` = 1.
  - Writing `mtimecmp` does not clear `pending`.
- Reset values:
  - `mtime` = 0, `mtimecmp` = `CMP_RESET`, `ctrl` = 0, `pending` = 0, `prescale` = 0.
  - `data_out` = 0, `valid` = 0, `irq` = 0.
- Reset mid-operation discards all state. A read accepted in the reset cycle produces no `valid`.
- Simultaneous `rd_ctrl` and `wr_ctrl` requests are both performed. The read returns the pre-write value.

## Timing
- Read latency 1: a read is sampled at edge N. `data_out` and `valid` update at edge N, are observed in cycle N+1, and carry the register value from before edge N.
- Writes take effect at the sampling edge and are visible to a read issued in the next cycle.
- `valid` deasserts the cycle after a read unless a new read is accepted. `data_out` holds its last value.
- `irq` is registered from `pending` and `ie`. It rises in the cycle after the matching tick edge and falls in the cycle after a W1C edge or an `ie` clear.
- Back-to-back reads are accepted every cycle. There is no stall or backpressure.

## Configuration
- `SYS_TIMER_PRESCALER_EN` defined:
  - `prescale` is a 16-bit register at 0x20, read/write, word or doubleword access.
  - A tick fires every `prescale`+1 cycles while `en` = 1. The first tick comes `prescale`+1 cycles after `en` rises.
  - The divider counter clears when `prescale` is written or `en` = 0.
- Macro not defined:
  - A tick fires every cycle while `en` = 1.
  - Offset 0x20 reads 0 and ignores writes; no divider logic is synthesized.

## Structure
- Package `sys_timer_pkg` holds:
  - offset constants (`OFF_MTIME`, `OFF_MTIMECMP`, `OFF_CTRL`, `OFF_STATUS`, `OFF_PRESCALE`);
  - `ctrl` bit indices;
  - a `bus_size_e` enum for the 3-bit access codes. The enum is shared with future bus peripherals.
- Sub-module `sys_timer_prescaler` contains the 16-bit divider; it takes `en`, `prescale` and a clear input and produces `tick`. It is instantiated only under `SYS_TIMER_PRESCALER_EN`.

## Test plan
- Reset, then read 0x08 as a doubleword → `valid` one cycle later, `data_out` = FFFF_FFFF_FFFF_FFFF; `irq` = 0.
- Write `mtimecmp` = 5, write `ctrl` = 0x5 (`en`, `ie`) → `pending` sets on the tick where `mtime` = 5, `irq` rises the next cycle, `mtime` keeps counting; W1C 0x18 → `irq` falls one cycle later.
- Periodic mode: `mtimecmp` = 3, `ctrl` = 0x7 → `mtime` sequence 0,1,2,3,0,1,… and `pending` sets at each 3.
- Write word 0x04 = 0xDEAD_BEEF while `mtime` = 0x10 → doubleword read returns DEAD_BEEF_0000_001x; a misaligned word write to 0x02 changes nothing.
- Write `mtime` in the same cycle as a tick, and W1C in the same cycle as a match → written value is kept, not incremented; `pending` stays 1.
- With `SYS_TIMER_PRESCALER_EN`, `prescale` = 3 and `en` = 1 → `mtime` increments every 4 cycles. Without the macro, a read of 0x20 after writing 3 returns 0.
